breakout_game_ctrl: RTL and testbench

Game-sequencing controller for the Breakout/pong display path. It owns the four-state game FSM (new game, play, new ball, over), the remaining-ball count, a frame-based wait timer and a 2-digit BCD score. It consumes hit/miss pulses from the graphics unit and a frame tick from the VGA counters. It drives the graphics freeze (gra_still) and the score digits shown on the 7-segment and text overlay.

---
 rtl/breakout_game_ctrl_if.sv | 28 ++
 rtl/breakout_game_ctrl.sv | 120 ++++++++++++
 tb/tb_breakout_game_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/breakout_game_ctrl_if.sv
// Signal bundle between the Breakout game controller and the graphics/VGA side.
// master: graphics/VGA/keys side; slave: the game controller.
interface breakout_game_ctrl_if #(
  parameter int unsigned LIFE_W = 2
);
  logic              frame_tick;
  logic              start_btn;
  logic              hit;
  logic              miss;
  logic [1:0]        state;
  logic              gra_still;
  logic [LIFE_W-1:0] balls_left;
  logic [3:0]        dig1;
  logic [3:0]        dig0;
  logic              timer_up;
  logic [3:0]        hi_dig1;
  logic [3:0]        hi_dig0;

  modport master (
    output frame_tick, start_btn, hit, miss,
    input  state, gra_still, balls_left, dig1, dig0, timer_up, hi_dig1, hi_dig0
  );

  modport slave (
    input  frame_tick, start_btn, hit, miss,
    output state, gra_still, balls_left, dig1, dig0, timer_up, hi_dig1, hi_dig0
  );
endinterface

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: game FSM, ball count, frame wait timer, 2-digit BCD score.
// Optional high-score register enabled by defining BREAKOUT_HISCORE_EN.
module breakout_game_ctrl #(
  parameter int unsigned BALLS       = 3,
  parameter int unsigned LIFE_W      = 2,
  parameter int unsigned WAIT_FRAMES = 120,
  parameter int unsigned TMR_W       = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  breakout_game_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    StNewGame = 2'b00,
    StPlay    = 2'b01,
    StNewBall = 2'b10,
    StOver    = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [LIFE_W-1:0] balls_q, balls_d;
  logic [3:0]        dig1_q, dig1_d;
  logic [3:0]        dig0_q, dig0_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              timer_up;
  logic              score_max;

  assign timer_up  = (tmr_q == '0);
  assign score_max = (dig1_q == 4'd9) && (dig0_q == 4'd9);

  always_comb begin
    state_d = state_q;
    balls_d = balls_q;
    dig1_d  = dig1_q;
    dig0_d  = dig0_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      StNewGame: begin
        balls_d = LIFE_W'(BALLS);
        dig1_d  = 4'd0;
        dig0_d  = 4'd0;
        if (bus.start_btn) state_d = StPlay;
      end
      StPlay: begin
        if (bus.hit && !score_max) begin
          if (dig0_q == 4'd9) begin
            dig0_d = 4'd0;
            dig1_d = dig1_q + 4'd1;
          end else begin
            dig0_d = dig0_q + 4'd1;
          end
        end
        // Timer load here also overrides any coincident frame_tick.
        if (bus.miss) begin
          balls_d = balls_q - LIFE_W'(1);
          tmr_d   = TMR_W'(WAIT_FRAMES);
          state_d = (balls_q == LIFE_W'(1)) ? StOver : StNewBall;
        end
      end
      StNewBall, StOver: begin
        if (!timer_up && bus.frame_tick) tmr_d = tmr_q - TMR_W'(1);
        if (timer_up) begin
          if (state_q == StOver) begin
            state_d = StNewGame;
            dig1_d  = 4'd0;
            dig0_d  = 4'd0;
            balls_d = LIFE_W'(BALLS);
          end else if (bus.start_btn) begin
            state_d = StPlay;
          end
        end
      end
      default: state_d = StNewGame;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StNewGame;
      balls_q <= LIFE_W'(BALLS);
      dig1_q  <= 4'd0;
      dig0_q  <= 4'd0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      balls_q <= balls_d;
      dig1_q  <= dig1_d;
      dig0_q  <= dig0_d;
      tmr_q   <= tmr_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.gra_still  = (state_q != StPlay);
  assign bus.balls_left = balls_q;
  assign bus.dig1       = dig1_q;
  assign bus.dig0       = dig0_q;
  assign bus.timer_up   = timer_up;

`ifdef BREAKOUT_HISCORE_EN
  logic [7:0] hi_q;

  // Valid BCD compares correctly as a plain binary byte, tens in the upper nibble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_q <= 8'h00;
    end else if (state_q == StPlay && state_d == StOver && {dig1_d, dig0_d} > hi_q) begin
      hi_q <= {dig1_d, dig0_d};
    end
  end

  assign bus.hi_dig1 = hi_q[7:4];
  assign bus.hi_dig0 = hi_q[3:0];
`else
  assign bus.hi_dig1 = 4'd0;
  assign bus.hi_dig0 = 4'd0;
`endif

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed self-checking bench for breakout_game_ctrl (default params: 3 balls, 120-frame wait).
module tb_breakout_game_ctrl;

`ifdef BREAKOUT_HISCORE_EN
  localparam bit HiEn = 1'b1;
`else
  localparam bit HiEn = 1'b0;
`endif

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  breakout_game_ctrl_if #(.LIFE_W(2)) bus ();

  breakout_game_ctrl #(
    .BALLS       (3),
    .LIFE_W      (2),
    .WAIT_FRAMES (120),
    .TMR_W       (8)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic serve();
    bus.start_btn = 1'b1;
    step();
    bus.start_btn = 1'b0;
  endtask

  task automatic hit_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.hit = 1'b1;
      step();
    end
    bus.hit = 1'b0;
  endtask

  // Each frame: one idle clk then one tick clk, so the tick is the last edge.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b0;
      step();
      bus.frame_tick = 1'b1;
      step();
    end
    bus.frame_tick = 1'b0;
  endtask

  task automatic play_game(input int n);
    serve();
    hit_n(n);
    for (int b = 0; b < 3; b++) begin
      bus.miss = 1'b1;
      step();
      bus.miss = 1'b0;
      frames(120);
      if (b < 2) serve();
      else step();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.frame_tick = 1'b0;
    bus.start_btn  = 1'b0;
    bus.hit        = 1'b0;
    bus.miss       = 1'b0;
    rstn = 1'b0;
    #23;
    check("rst_state", bus.state, 2'b00);
    check("rst_still", bus.gra_still, 1'b1);
    check("rst_balls", bus.balls_left, 2'd3);
    check("rst_score", {bus.dig1, bus.dig0}, 8'h00);
    check("rst_tup", bus.timer_up, 1'b1);
    check("rst_hi", {bus.hi_dig1, bus.hi_dig0}, 8'h00);
    rstn = 1'b1;
    step();
    check("idle_state", bus.state, 2'b00);

    // Game 1: serve, score, miss and a held serve button.
    serve();
    check("play_state", bus.state, 2'b01);
    check("play_still", bus.gra_still, 1'b0);
    check("play_balls", bus.balls_left, 2'd3);
    check("play_score", {bus.dig1, bus.dig0}, 8'h00);
    hit_n(12);
    check("score_12", {bus.dig1, bus.dig0}, 8'h12);
    bus.miss = 1'b1;
    step();
    bus.miss = 1'b0;
    check("nb_state", bus.state, 2'b10);
    check("nb_balls", bus.balls_left, 2'd2);
    check("nb_tup", bus.timer_up, 1'b0);
    check("nb_still", bus.gra_still, 1'b1);
    bus.start_btn = 1'b1;
    frames(119);
    check("nb_btn_ignored", bus.state, 2'b10);
    check("nb_tup_119", bus.timer_up, 1'b0);
    frames(1);
    check("nb_tup_120", bus.timer_up, 1'b1);
    check("nb_state_120", bus.state, 2'b10);
    step();
    bus.start_btn = 1'b0;
    check("reserve_state", bus.state, 2'b01);
    check("reserve_score", {bus.dig1, bus.dig0}, 8'h12);
    hit_n(1);
    bus.miss = 1'b1;
    step();
    bus.miss = 1'b0;
    check("nb2_balls", bus.balls_left, 2'd1);
    frames(70);
    check("nb2_tup", bus.timer_up, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_state", bus.state, 2'b00);
    check("arst_score", {bus.dig1, bus.dig0}, 8'h00);
    check("arst_balls", bus.balls_left, 2'd3);
    check("arst_still", bus.gra_still, 1'b1);
    check("arst_tup", bus.timer_up, 1'b1);
    rstn = 1'b1;
    step();

    // Game 2: score saturation.
    serve();
    hit_n(100);
    check("score_sat", {bus.dig1, bus.dig0}, 8'h99);
    #2;
    rstn = 1'b0;
    #3;
    rstn = 1'b1;
    step();

    // Game 3: load beats frame_tick, hit+miss on the last ball, automatic restart.
    serve();
    hit_n(5);
    bus.miss = 1'b1;
    step();
    bus.miss = 1'b0;
    frames(120);
    serve();
    check("g3_play", bus.state, 2'b01);
    bus.miss = 1'b1;
    bus.frame_tick = 1'b1;
    step();
    bus.miss = 1'b0;
    bus.frame_tick = 1'b0;
    frames(119);
    check("load_wins_tup", bus.timer_up, 1'b0);
    frames(1);
    check("load_wins_exp", bus.timer_up, 1'b1);
    serve();
    check("g3_balls1", bus.balls_left, 2'd1);
    bus.hit = 1'b1;
    bus.miss = 1'b1;
    step();
    bus.hit = 1'b0;
    bus.miss = 1'b0;
    check("hm_score", {bus.dig1, bus.dig0}, 8'h06);
    check("hm_balls", bus.balls_left, 2'd0);
    check("hm_state", bus.state, 2'b11);
    check("over_still", bus.gra_still, 1'b1);
    hit_n(1);
    check("over_hit_ign", {bus.dig1, bus.dig0}, 8'h06);
    frames(120);
    check("over_state_120", bus.state, 2'b11);
    check("over_tup", bus.timer_up, 1'b1);
    step();
    check("ng_state", bus.state, 2'b00);
    check("ng_score", {bus.dig1, bus.dig0}, 8'h00);
    check("ng_balls", bus.balls_left, 2'd3);
    check("hi_g3", {bus.hi_dig1, bus.hi_dig0}, HiEn ? 8'h06 : 8'h00);

    // High-score sequence across games without reset.
    play_game(7);
    check("g4_state", bus.state, 2'b00);
    check("hi_07", {bus.hi_dig1, bus.hi_dig0}, HiEn ? 8'h07 : 8'h00);
    play_game(3);
    check("hi_keep", {bus.hi_dig1, bus.hi_dig0}, HiEn ? 8'h07 : 8'h00);
    play_game(15);
    check("hi_15", {bus.hi_dig1, bus.hi_dig0}, HiEn ? 8'h15 : 8'h00);
    check("g6_score", {bus.dig1, bus.dig0}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
